// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for seven-segment encode/decode.
//   SEG_BLANK  - active-low pattern with every segment off
//   SEG_CODES  - legal active-low pattern for each nibble 0..F (bit0=a .. bit6=g)
//   state_e    - capture FSM states
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_to_nibble.sv
// seg7_to_nibble: combinational reverse lookup of an active-low segment
// pattern into its nibble.
//   seg_i    [6:0] active-low segment pattern
//   nibble_o [3:0] recovered nibble (0 when the pattern is illegal)
//   legal_o        pattern is one of the 16 legal codes
module seg7_to_nibble
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       legal_o
);

  always_comb begin
    nibble_o = '0;
    legal_o  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_CODES[i]) begin
        nibble_o = 4'(i);
        legal_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: recovers the nibbles shown on a multiplexed active-low
// seven-segment bus and holds them per digit with valid flags.
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   seg_in  [6:0] active-low segment lines (asynchronous)
//   dig_sel [N-1:0] one-hot digit select (asynchronous)
//   value_o [4N-1:0] recovered nibbles, digit i at [4i+3:4i]
//   digit_valid_o [N-1:0] digit i holds a valid capture
//   update_o      one-cycle pulse when a stored nibble/valid bit changes
//   err_o         one-cycle pulse when a stable pattern is illegal
//
// state  | meaning
// WAIT   | digit select is not one-hot; nothing to track
// SETTLE | counting cycles of an unchanged {seg, dig} sample
// HOLD   | current sample captured; waiting for the next change
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] value_o,
  output logic [NUM_DIGITS-1:0]   digit_valid_o,
  output logic                    update_o,
  output logic                    err_o
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [6:0]            seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NUM_DIGITS-1:0] dig_s1_q, dig_s2_q, dig_prev_q;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cap_q, cap_d;

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    update_q, update_d;
  logic                    err_q, err_d;

  logic                  dig_onehot;
  logic                  changed;
  logic [3:0]            cap_nibble;
  logic                  cap_legal;

  // prev_q doubles as the capture source: on the cycle after a capture
  // decision it holds exactly the sample that was judged stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= SEG_BLANK;
      seg_s2_q   <= SEG_BLANK;
      seg_prev_q <= SEG_BLANK;
      dig_s1_q   <= '0;
      dig_s2_q   <= '0;
      dig_prev_q <= '0;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      dig_s1_q   <= dig_sel;
      dig_s2_q   <= dig_s1_q;
      dig_prev_q <= dig_s2_q;
    end
  end

  assign dig_onehot = $onehot(dig_s2_q);
  assign changed    = {seg_s2_q, dig_s2_q} != {seg_prev_q, dig_prev_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = 1'b0;
    case (state_q)
      WAIT: begin
        cnt_d = '0;
        if (dig_onehot) state_d = SETTLE;
      end
      SETTLE: begin
        if (!dig_onehot) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cap_d   = 1'b1;
          state_d = HOLD;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (!dig_onehot) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (changed) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  seg7_to_nibble u_dec (
    .seg_i    (seg_prev_q),
    .nibble_o (cap_nibble),
    .legal_o  (cap_legal)
  );

  always_comb begin
    value_d  = value_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    if (cap_q) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_prev_q[i]) begin
          if (cap_legal) begin
            if (!valid_q[i] || (value_q[4*i +: 4] != cap_nibble)) update_d = 1'b1;
            value_d[4*i +: 4] = cap_nibble;
            valid_d[i]        = 1'b1;
          end else begin
            err_d      = 1'b1;
            update_d   = valid_q[i];
            valid_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT;
      cnt_q    <= '0;
      cap_q    <= 1'b0;
      value_q  <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign value_o       = value_q;
  assign digit_valid_o = valid_q;
  assign update_o      = update_q;
  assign err_o         = err_q;

endmodule
